// File: rtl/mddr_pkg.sv
// Shared constants for the mobile-DDR init/refresh sequencer: command encodings,
// FSM state type and default 50 MHz timing values.
package mddr_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdLmr = 4'b0000;

  // a[10] selects all banks for PRECHARGE
  localparam logic [12:0] PreAllAddr = 13'h0400;
  localparam logic [1:0]  BaMrs      = 2'b00;
  localparam logic [1:0]  BaEmrs     = 2'b10;

  localparam int unsigned DefTPwrup  = 10000;
  localparam int unsigned DefTRp     = 2;
  localparam int unsigned DefTRfc    = 4;
  localparam int unsigned DefTMrd    = 2;
  localparam int unsigned DefTRefi   = 390;
  localparam logic [12:0] DefMrVal   = 13'h031;
  localparam logic [12:0] DefEmrVal  = 13'h000;
  localparam int unsigned DefMaxDebt = 7;

  typedef enum logic [3:0] {
    StPwrup,
    StCkeOn,
    StPre,
    StRef1,
    StRef2,
    StMrs,
    StEmrs,
    StRun,
    StRpre,
    StRref
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold values 0 .. v-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mddr_refresh_timer.sv
// Refresh interval timer with a saturating count of owed refreshes and a sticky
// overflow flag; counting begins once enable rises and never stops until reset.
module mddr_refresh_timer
  import mddr_pkg::*;
#(
  parameter int unsigned T_REFI   = DefTRefi,
  parameter int unsigned MAX_DEBT = DefMaxDebt
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic dec,
  output logic pending_d,
  output logic ref_err
);

  localparam int unsigned TimW  = cnt_width(T_REFI);
  localparam int unsigned DebtW = cnt_width(MAX_DEBT + 1);

  localparam logic [TimW-1:0]  Reload  = TimW'(T_REFI - 1);
  localparam logic [DebtW-1:0] DebtMax = DebtW'(MAX_DEBT);

  logic [TimW-1:0]  cnt_q;
  logic [DebtW-1:0] debt_q, debt_d;
  logic             err_q;
  logic             expire;

  assign expire = enable && (cnt_q == '0);

  // Expiry and completion in the same cycle cancel out.
  always_comb begin
    debt_d = debt_q;
    if (expire && !dec) begin
      if (debt_q != DebtMax) debt_d = debt_q + DebtW'(1);
    end else if (dec && !expire) begin
      if (debt_q != '0) debt_d = debt_q - DebtW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= Reload;
      debt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!enable || cnt_q == '0) cnt_q <= Reload;
      else                        cnt_q <= cnt_q - TimW'(1);
      debt_q <= debt_d;
      if (expire && debt_q == DebtMax) err_q <= 1'b1;
    end
  end

  assign pending_d = (debt_d != '0);
  assign ref_err   = err_q;

endmodule

// File: rtl/mddr_init_refresh.sv
// Mobile-DDR power-up sequencer and periodic refresh scheduler; owns the SDRAM
// command bus and lends it to the read/write engine between refreshes.
module mddr_init_refresh
  import mddr_pkg::*;
#(
  parameter int unsigned T_PWRUP  = DefTPwrup,
  parameter int unsigned T_RP     = DefTRp,
  parameter int unsigned T_RFC    = DefTRfc,
  parameter int unsigned T_MRD    = DefTMrd,
  parameter int unsigned T_REFI   = DefTRefi,
  parameter logic [12:0] MR_VAL   = DefMrVal,
  parameter logic [12:0] EMR_VAL  = DefEmrVal,
  parameter int unsigned MAX_DEBT = DefMaxDebt
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eng_cs_n,
  input  logic        eng_ras_n,
  input  logic        eng_cas_n,
  input  logic        eng_we_n,
  input  logic [12:0] eng_a,
  input  logic [1:0]  eng_ba,
  input  logic        ref_ack,
  output logic        ref_req,
  output logic        init_done,
  output logic        ref_err,
  output logic        mddr_cke,
  output logic        mddr_cs_n,
  output logic        mddr_ras_n,
  output logic        mddr_cas_n,
  output logic        mddr_we_n,
  output logic [12:0] mddr_a,
  output logic [1:0]  mddr_ba
);

  localparam int unsigned CntW = cnt_width(max_u(T_PWRUP, T_REFI));

  localparam logic [CntW-1:0] WaitPwrup = CntW'(T_PWRUP - 1);
  localparam logic [CntW-1:0] WaitRp    = CntW'(T_RP - 1);
  localparam logic [CntW-1:0] WaitRfc   = CntW'(T_RFC - 1);
  localparam logic [CntW-1:0] WaitMrd   = CntW'(T_MRD - 1);

  state_e          state_q;
  logic [CntW-1:0] wait_cnt;
  logic [3:0]      cmd_q;
  logic [12:0]     a_q;
  logic [1:0]      ba_q;
  logic            cke_q;
  logic            init_done_q;
  logic            ref_req_q;
  logic            pending_d;
  logic            ref_done;
  logic [3:0]      eng_cmd;

  assign eng_cmd  = {eng_cs_n, eng_ras_n, eng_cas_n, eng_we_n};
  assign ref_done = (state_q == StRref) && (wait_cnt == '0);

  mddr_refresh_timer #(
    .T_REFI   (T_REFI),
    .MAX_DEBT (MAX_DEBT)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (init_done_q),
    .dec       (ref_done),
    .pending_d (pending_d),
    .ref_err   (ref_err)
  );

  // Each state drives its command on entry, then NOPs until wait_cnt drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPwrup;
      wait_cnt    <= WaitPwrup;
      cmd_q       <= CmdNop;
      a_q         <= '0;
      ba_q        <= '0;
      cke_q       <= 1'b0;
      init_done_q <= 1'b0;
      ref_req_q   <= 1'b0;
    end else begin
      cmd_q     <= CmdNop;
      a_q       <= '0;
      ba_q      <= '0;
      ref_req_q <= 1'b0;
      if (wait_cnt != '0) wait_cnt <= wait_cnt - CntW'(1);

      unique case (state_q)
        StPwrup: begin
          if (wait_cnt == '0) begin
            state_q <= StCkeOn;
            cke_q   <= 1'b1;
          end
        end
        StCkeOn: begin
          state_q  <= StPre;
          wait_cnt <= WaitRp;
          cmd_q    <= CmdPre;
          a_q      <= PreAllAddr;
        end
        StPre: begin
          if (wait_cnt == '0) begin
            state_q  <= StRef1;
            wait_cnt <= WaitRfc;
            cmd_q    <= CmdRef;
          end
        end
        StRef1: begin
          if (wait_cnt == '0) begin
            state_q  <= StRef2;
            wait_cnt <= WaitRfc;
            cmd_q    <= CmdRef;
          end
        end
        StRef2: begin
          if (wait_cnt == '0) begin
            state_q  <= StMrs;
            wait_cnt <= WaitMrd;
            cmd_q    <= CmdLmr;
            a_q      <= MR_VAL;
            ba_q     <= BaMrs;
          end
        end
        StMrs: begin
          if (wait_cnt == '0) begin
            state_q  <= StEmrs;
            wait_cnt <= WaitMrd;
            cmd_q    <= CmdLmr;
            a_q      <= EMR_VAL;
            ba_q     <= BaEmrs;
          end
        end
        StEmrs: begin
          // Engine is not yet trusted on this edge, so RUN starts with a NOP.
          if (wait_cnt == '0) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
            ref_req_q   <= pending_d;
          end
        end
        StRun: begin
          if (ref_req_q && ref_ack) begin
            state_q  <= StRpre;
            wait_cnt <= WaitRp;
            cmd_q    <= CmdPre;
            a_q      <= PreAllAddr;
          end else begin
            cmd_q     <= eng_cmd;
            a_q       <= eng_a;
            ba_q      <= eng_ba;
            ref_req_q <= pending_d;
          end
        end
        StRpre: begin
          if (wait_cnt == '0) begin
            state_q  <= StRref;
            wait_cnt <= WaitRfc;
            cmd_q    <= CmdRef;
          end
        end
        StRref: begin
          if (wait_cnt == '0) begin
            state_q   <= StRun;
            cmd_q     <= eng_cmd;
            a_q       <= eng_a;
            ba_q      <= eng_ba;
            ref_req_q <= pending_d;
          end
        end
        default: begin
          state_q  <= StPwrup;
          wait_cnt <= WaitPwrup;
          cke_q    <= 1'b0;
        end
      endcase
    end
  end

  assign {mddr_cs_n, mddr_ras_n, mddr_cas_n, mddr_we_n} = cmd_q;
  assign mddr_a    = a_q;
  assign mddr_ba   = ba_q;
  assign mddr_cke  = cke_q;
  assign init_done = init_done_q;
  assign ref_req   = ref_req_q;

endmodule
